// File: rtl/distortion_sched.v
// Legacy Verilog entry point; the distortion_sched design is in distortion_sched.sv.

// File: rtl/distortion_sched.sv
// Stereo clip sequencer: one shared soft/hard clipper serves L then R per frame.
// Drive level and enable are latched at the capture edge so a frame never mixes settings.
module distortion_sched #(
  parameter int SOFT_STEP    = 3750000,
  parameter int RESET_LEVEL  = 3,
  parameter int BYPASS_SHIFT = 10
) (
  input  logic        CLOCK_50,
  input  logic        reset_n,
  input  logic        sample_valid,
  input  logic [31:0] in_L,
  input  logic [31:0] in_R,
  input  logic        enable,
  input  logic        drive_up,
  input  logic        drive_down,
  output logic [31:0] out_L,
  output logic [31:0] out_R,
  output logic        out_valid,
  output logic        busy,
  output logic [2:0]  drive_level,
  output logic        overrun
);

  typedef enum logic [1:0] {IDLE, PROC_L, PROC_R, DONE} state_t;
  localparam logic [2:0] RST_LVL = 3'(RESET_LEVEL);

  state_t state, state_nx;
  logic [31:0] fr_l, fr_r, res_l, clip_y, clip_x;
  logic        fr_en;
  logic [2:0]  fr_lvl, pend_lvl;
  logic        capture;

  logic signed [32:0] xe, nx, s_th, h_th, t;
  logic signed [41:0] sh;

  assign busy    = (state != IDLE);
  assign capture = (state == IDLE) && sample_valid;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (sample_valid) state_nx = PROC_L;
      PROC_L:  state_nx = PROC_R;
      PROC_R:  state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  // Shared clipper; 33-bit intermediates keep -2^31 negatable.
  always_comb begin
    clip_x = (state == PROC_L) ? fr_l : fr_r;
    xe     = {clip_x[31], clip_x};
    nx     = -xe;
    s_th   = 33'(SOFT_STEP * (32'(fr_lvl) + 32'd1));
    h_th   = s_th <<< 1;
    sh     = 42'(xe) <<< BYPASS_SHIFT;
    t      = xe;
    clip_y = clip_x;
    if (!fr_en) begin
      if (sh > 42'sd2147483647)        clip_y = 32'h7FFF_FFFF;
      else if (sh < -42'sd2147483648)  clip_y = 32'h8000_0000;
      else                             clip_y = sh[31:0];
    end else if (!xe[32]) begin
      if (xe < s_th)       t = xe;
      else if (xe < h_th)  t = s_th + ((xe - s_th) >>> 1);
      else                 t = h_th;
      clip_y = t[31:0];
    end else begin
      if (xe > -s_th)      t = xe;
      else if (xe > -h_th) t = -s_th - ((nx - s_th) >>> 1);
      else                 t = -h_th;
      clip_y = t[31:0];
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      fr_l        <= '0;
      fr_r        <= '0;
      fr_en       <= 1'b0;
      fr_lvl      <= RST_LVL;
      res_l       <= '0;
      out_L       <= '0;
      out_R       <= '0;
      out_valid   <= 1'b0;
      overrun     <= 1'b0;
      pend_lvl    <= RST_LVL;
      drive_level <= RST_LVL;
    end else begin
      state     <= state_nx;
      out_valid <= 1'b0;
      if (sample_valid && state != IDLE) overrun <= 1'b1;
      if (drive_up && !drive_down && pend_lvl != 3'd7)      pend_lvl <= pend_lvl + 3'd1;
      else if (drive_down && !drive_up && pend_lvl != 3'd0) pend_lvl <= pend_lvl - 3'd1;
      if (capture) begin
        fr_l        <= in_L;
        fr_r        <= in_R;
        fr_en       <= enable;
        fr_lvl      <= pend_lvl;
        drive_level <= pend_lvl;
      end
      if (state == PROC_L) res_l <= clip_y;
      if (state == PROC_R) begin
        out_L     <= res_l;
        out_R     <= clip_y;
        out_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_distortion_sched.sv
// Directed + randomized checks of distortion_sched against an arithmetic clip model.
module tb_distortion_sched;
  logic        CLOCK_50 = 1'b0, reset_n = 1'b0, sample_valid = 1'b0;
  logic [31:0] in_L = '0, in_R = '0;
  logic        enable = 1'b0, drive_up = 1'b0, drive_down = 1'b0;
  logic [31:0] out_L, out_R;
  logic        out_valid, busy, overrun;
  logic [2:0]  drive_level;

  int total = 0, bad = 0;
  int m_pend = 3, m_lvl = 3;

  distortion_sched dut (
    .CLOCK_50(CLOCK_50), .reset_n(reset_n), .sample_valid(sample_valid),
    .in_L(in_L), .in_R(in_R), .enable(enable), .drive_up(drive_up),
    .drive_down(drive_down), .out_L(out_L), .out_R(out_R), .out_valid(out_valid),
    .busy(busy), .drive_level(drive_level), .overrun(overrun)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  function automatic longint model(input longint x, input int lvl, input bit en);
    longint s, h, y;
    s = 64'd3750000 * longint'(lvl + 1);
    h = 2 * s;
    if (!en) begin
      y = x * 1024;
      if (y > 64'sd2147483647) y = 64'sd2147483647;
      if (y < -64'sd2147483648) y = -64'sd2147483648;
    end else if (x >= 0) y = (x < s) ? x : (x < h) ? s + (x - s) / 2 : h;
    else y = (x > -s) ? x : (x > -h) ? -s - (-x - s) / 2 : -h;
    return y;
  endfunction

  task automatic chk(input string tag, input longint obs, input longint exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK_50); #1;
  endtask

  task automatic pulse(input bit up, input bit dn);
    drive_up = up; drive_down = dn;
    tick();
    drive_up = 1'b0; drive_down = 1'b0;
    if (up && !dn && m_pend < 7) m_pend++;
    else if (dn && !up && m_pend > 0) m_pend--;
  endtask

  task automatic send(input int l, input int r, input bit en, input bit mid);
    int n;
    longint el, er;
    in_L = l; in_R = r; enable = en; sample_valid = 1'b1;
    m_lvl = m_pend;
    el = model(longint'(l), m_lvl, en);
    er = model(longint'(r), m_lvl, en);
    tick();
    sample_valid = 1'b0;
    chk("lvl_at_capture", drive_level, m_lvl);
    chk("busy_after_capture", busy, 1);
    n = 0;
    if (mid) begin
      enable = ~en;
      pulse(1'b1, 1'b0);
      n = 1;
      chk("no_early_valid", out_valid, 0);
    end
    while (!out_valid && n < 6) begin tick(); n++; end
    chk("latency", n, 2);
    chk("out_L", longint'($signed(out_L)), el);
    chk("out_R", longint'($signed(out_R)), er);
    tick();
    chk("valid_one_cycle", out_valid, 0);
    chk("hold_L", longint'($signed(out_L)), el);
  endtask

  initial begin
    int bc, vc, l, r;
    #25 reset_n = 1'b1;
    #1;
    chk("rst_out_L", out_L, 0);
    chk("rst_out_R", out_R, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_busy", busy, 0);
    chk("rst_level", drive_level, 3);
    tick();

    send(10000000, -20000000, 1'b1, 1'b0);
    chk("plan1_R", longint'($signed(out_R)), -17500000);
    send(40000000, int'(32'h8000_0000), 1'b1, 1'b0);
    chk("plan2_R", longint'($signed(out_R)), -30000000);
    send(1000, 3000000, 1'b0, 1'b0);
    chk("plan3_R", out_R, 32'h7FFF_FFFF);
    send(-5000000, int'(32'h8000_0000), 1'b0, 1'b0);

    for (int i = 0; i < 5; i++) pulse(1'b1, 1'b0);
    chk("level_before_capture", drive_level, 3);
    pulse(1'b1, 1'b1);
    send(20000000, -70000000, 1'b1, 1'b0);
    chk("level_after_capture", drive_level, 7);
    chk("plan4_L", longint'($signed(out_L)), 20000000);

    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 1) == 1) begin l = int'($urandom); r = int'($urandom); end
      else begin
        l = int'($urandom_range(0, 120000000)) - 60000000;
        r = int'($urandom_range(0, 120000000)) - 60000000;
      end
      if ($urandom_range(0, 2) == 0) pulse($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
      if ($urandom_range(0, 3) == 0) pulse(1'b0, 1'b1);
      send(l, r, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
    end
    chk("no_overrun_yet", overrun, 0);

    in_L = 25000000; in_R = -25000000; enable = 1'b1; sample_valid = 1'b1;
    m_lvl = m_pend;
    bc = 0; vc = 0;
    tick();
    bc += int'(busy);
    tick();
    sample_valid = 1'b0;
    bc += int'(busy);
    chk("overrun_set", overrun, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      bc += int'(busy);
      if (out_valid) begin
        vc++;
        chk("ovr_out_L", longint'($signed(out_L)), model(25000000, m_lvl, 1'b1));
        chk("ovr_out_R", longint'($signed(out_R)), model(-25000000, m_lvl, 1'b1));
      end
    end
    chk("busy_cycles", bc, 3);
    chk("one_frame", vc, 1);
    repeat (3) tick();
    chk("overrun_sticky", overrun, 1);

    in_L = 12345678; in_R = -1; enable = 1'b1; sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    tick();
    reset_n = 1'b0;
    #2;
    chk("midrst_L", out_L, 0);
    chk("midrst_R", out_R, 0);
    chk("midrst_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_overrun", overrun, 0);
    m_pend = 3;
    #5 reset_n = 1'b1;
    vc = 0;
    for (int i = 0; i < 4; i++) begin tick(); vc += int'(out_valid); end
    chk("midrst_no_valid", vc, 0);
    send(50000000, -16000000, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
